// File: rtl/morse_link_if.sv
// Key/arbitration bundle between the raw key pins and the arbiter outputs.
// Level semantics only: keys are sampled every clk, outputs are registered and valid every cycle.
interface morse_link_if;
  logic       local_key;
  logic       remote_key;
  logic       key_out;
  logic       tx_out;
  logic [1:0] owner;
  logic       talker_change;
  logic       collision;
  logic [1:0] arb_state;

  modport master (
    output local_key, remote_key,
    input  key_out, tx_out, owner, talker_change, collision, arb_state
  );

  modport slave (
    input  local_key, remote_key,
    output key_out, tx_out, owner, talker_change, collision, arb_state
  );
endinterface

// File: rtl/morse_link_arbiter.sv
// Half-duplex arbiter: synchronises/debounces the local and remote keys and grants
// the interpreter datapath to one of them, with idle timeout and a hold-off window.
module morse_link_arbiter #(
  parameter int DEBOUNCE        = 5,
  parameter int IDLE_TIMEOUT    = 3000,
  parameter int HOLDOFF         = 200,
  parameter int REMOTE_PRIORITY = 1,
  parameter int CNT_W           = 12
) (
  input  logic         clk,
  input  logic         rst,
  morse_link_if.slave  link
);

  localparam int              DB_W      = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [1:0]      OWN_NONE   = 2'b00;
  localparam logic [1:0]      OWN_LOCAL  = 2'b01;
  localparam logic [1:0]      OWN_REMOTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCAL   = 2'd1,
    ST_REMOTE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // Bit 0 is the local key, bit 1 the remote key throughout.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_d1;
  logic [1:0]      seen_low;
  logic [1:0]      fill;
  logic [1:0]      rise;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {link.remote_key, link.local_key};

  // seen_low arms rise detection only once a key has been observed released after
  // reset, so a key held through reset cannot grab the link when it debounces high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db       <= '0;
      db_d1    <= '0;
      seen_low <= '0;
      fill     <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      db_d1    <= db;
      fill     <= {fill[0], 1'b1};
      seen_low <= seen_low | ({2{fill[1]}} & ~sync2);
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db & ~db_d1 & seen_low;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       last_q;
  logic [1:0]       last_nxt;
  logic [1:0]       grant;
  logic             tc_nxt;
  logic             col_nxt;
  logic [1:0]       owner_nxt;
  logic             key_nxt;
  logic             tx_nxt;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    last_nxt  = last_q;
    grant     = OWN_NONE;
    tc_nxt    = 1'b0;
    col_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise[1] && (!rise[0] || (REMOTE_PRIORITY != 0))) begin
          grant = OWN_REMOTE;
        end else if (rise[0]) begin
          grant = OWN_LOCAL;
        end
        if (grant != OWN_NONE) begin
          state_nxt = (grant == OWN_REMOTE) ? ST_REMOTE : ST_LOCAL;
          tc_nxt    = (grant != last_q);
          last_nxt  = grant;
        end
      end
      ST_LOCAL: begin
        col_nxt = rise[1];
        if (!db[0]) begin
          if (cnt_q == IDLE_LAST) state_nxt = ST_HOLDOFF;
          else                    cnt_nxt   = cnt_inc;
        end
      end
      ST_REMOTE: begin
        col_nxt = rise[0];
        if (!db[1]) begin
          if (cnt_q == IDLE_LAST) state_nxt = ST_HOLDOFF;
          else                    cnt_nxt   = cnt_inc;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) state_nxt = ST_IDLE;
        else                    cnt_nxt   = cnt_inc;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    owner_nxt = OWN_NONE;
    key_nxt   = 1'b0;
    tx_nxt    = 1'b0;
    case (state_nxt)
      ST_LOCAL: begin
        owner_nxt = OWN_LOCAL;
        key_nxt   = db[0];
        tx_nxt    = db[0];
      end
      ST_REMOTE: begin
        owner_nxt = OWN_REMOTE;
        key_nxt   = db[1];
      end
      default: begin
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      cnt_q              <= '0;
      last_q             <= OWN_NONE;
      link.owner         <= OWN_NONE;
      link.key_out       <= 1'b0;
      link.tx_out        <= 1'b0;
      link.talker_change <= 1'b0;
      link.collision     <= 1'b0;
    end else begin
      state_q            <= state_nxt;
      cnt_q              <= cnt_nxt;
      last_q             <= last_nxt;
      link.owner         <= owner_nxt;
      link.key_out       <= key_nxt;
      link.tx_out        <= tx_nxt;
      link.talker_change <= tc_nxt;
      link.collision     <= col_nxt;
    end
  end

  assign link.arb_state = state_q;

endmodule

// File: tb/tb_morse_link_arbiter.sv
// Bench for morse_link_arbiter: two instances (remote priority and local priority)
// share the key stimulus; grant/collision events are scored through an expected queue.
module tb_morse_link_arbiter;

  logic clk;
  logic rst;
  logic local_key;
  logic remote_key;

  morse_link_if bus1 ();
  morse_link_if bus0 ();

  assign bus1.local_key  = local_key;
  assign bus1.remote_key = remote_key;
  assign bus0.local_key  = local_key;
  assign bus0.remote_key = remote_key;

  morse_link_arbiter #(.REMOTE_PRIORITY(1)) dut1 (.clk(clk), .rst(rst), .link(bus1.slave));
  morse_link_arbiter #(.REMOTE_PRIORITY(0)) dut0 (.clk(clk), .rst(rst), .link(bus0.slave));

  // {owner[1:0], key_out, tx_out, talker_change, collision}
  logic [5:0] obs1;
  logic [5:0] obs0;
  assign obs1 = {bus1.owner, bus1.key_out, bus1.tx_out, bus1.talker_change, bus1.collision};
  assign obs0 = {bus0.owner, bus0.key_out, bus0.tx_out, bus0.talker_change, bus0.collision};

  logic [5:0] exp_q[$];
  int checks;
  int errors;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    local_key = 1'b0;
    remote_key = 1'b0;
    tick(3);
    checks++;
    if (obs1 !== 6'b0 || bus1.arb_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut1: got %b state %0d expected 000000 state 0", obs1, bus1.arb_state);
    end
    checks++;
    if (obs0 !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut0: got %b expected 000000", obs0);
    end
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_glitch();
    remote_key = 1'b1;
    tick(3);
    remote_key = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++;
      if (bus1.owner !== 2'b00 || bus1.key_out !== 1'b0) begin
        errors++;
        $display("FAIL glitch_cycle%0d: owner %b key_out %b expected 00 0", i, bus1.owner, bus1.key_out);
      end
    end
  endtask

  task automatic test_local_grant();
    logic [5:0] exp_v;
    local_key = 1'b1;
    exp_q.push_back({2'b01, 1'b1, 1'b1, 1'b1, 1'b0});
    tick(7);
    checks++;
    if (bus1.owner !== 2'b00) begin
      errors++;
      $display("FAIL t1_before_latency: owner %b expected 00", bus1.owner);
    end
    tick(1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t1_grant: scoreboard empty, got %b", obs1);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs1 !== exp_v) begin
        errors++;
        $display("FAIL t1_grant: got %b expected %b", obs1, exp_v);
      end
    end
    for (int i = 0; i < 11; i++) begin
      tick(1);
      checks++;
      if (obs1 !== {2'b01, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL t1_hold_cycle%0d: got %b expected 011100", i, obs1);
      end
    end
    local_key = 1'b0;
    tick(7);
    checks++;
    if (bus1.key_out !== 1'b1) begin
      errors++;
      $display("FAIL t1_release_latency: key_out %b expected 1", bus1.key_out);
    end
    tick(1);
    checks++;
    if (obs1 !== {2'b01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL t1_release: got %b expected 010000", obs1);
    end
  endtask

  task automatic test_collision();
    logic [5:0] exp_v;
    local_key = 1'b1;
    remote_key = 1'b1;
    exp_q.push_back({2'b01, 1'b1, 1'b1, 1'b0, 1'b1});
    tick(8);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t4_collision: scoreboard empty, got %b", obs1);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs1 !== exp_v) begin
        errors++;
        $display("FAIL t4_collision: got %b expected %b", obs1, exp_v);
      end
    end
    for (int i = 9; i <= 20; i++) begin
      if (i == 11) remote_key = 1'b0;
      tick(1);
      checks++;
      if (obs1 !== {2'b01, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL t4_track_cycle%0d: got %b expected 011100", i, obs1);
      end
    end
  endtask

  task automatic test_timeout_holdoff();
    logic [5:0] exp_v;
    local_key = 1'b0;
    tick(3006);
    checks++;
    if (bus1.owner !== 2'b01 || bus1.key_out !== 1'b0) begin
      errors++;
      $display("FAIL t5_pre_timeout: owner %b key_out %b expected 01 0", bus1.owner, bus1.key_out);
    end
    tick(1);
    checks++;
    if (obs1 !== 6'b0 || bus1.arb_state !== 2'd3) begin
      errors++;
      $display("FAIL t5_timeout: got %b state %0d expected 000000 state 3", obs1, bus1.arb_state);
    end
    for (int i = 1; i < 200; i++) begin
      if (i == 10) remote_key = 1'b1;
      if (i == 40) remote_key = 1'b0;
      tick(1);
      checks++;
      if (obs1 !== 6'b0 || bus1.arb_state !== 2'd3) begin
        errors++;
        $display("FAIL t5_holdoff_cycle%0d: got %b state %0d expected 000000 state 3", i, obs1, bus1.arb_state);
      end
    end
    tick(1);
    checks++;
    if (bus1.arb_state !== 2'd0 || bus1.owner !== 2'b00) begin
      errors++;
      $display("FAIL t5_holdoff_end: state %0d owner %b expected 0 00", bus1.arb_state, bus1.owner);
    end
    tick(10);
    remote_key = 1'b1;
    exp_q.push_back({2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
    tick(8);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t5_remote_grant: scoreboard empty, got %b", obs1);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs1 !== exp_v) begin
        errors++;
        $display("FAIL t5_remote_grant: got %b expected %b", obs1, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_owner();
    logic [5:0] exp_v;
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs1 !== 6'b0 || bus1.arb_state !== 2'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got %b state %0d expected 000000 state 0", obs1, bus1.arb_state);
    end
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (obs1 !== 6'b0) begin
        errors++;
        $display("FAIL t6_held_key_cycle%0d: got %b expected 000000", i, obs1);
      end
    end
    remote_key = 1'b0;
    tick(20);
    remote_key = 1'b1;
    exp_q.push_back({2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
    tick(8);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t6_regrant: scoreboard empty, got %b", obs1);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs1 !== exp_v) begin
        errors++;
        $display("FAIL t6_regrant: got %b expected %b", obs1, exp_v);
      end
    end
    remote_key = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_v;
    rst = 1'b1;
    local_key = 1'b0;
    remote_key = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    local_key = 1'b1;
    remote_key = 1'b1;
    exp_q.push_back({2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
    exp_q.push_back({2'b01, 1'b1, 1'b1, 1'b1, 1'b0});
    tick(7);
    checks++;
    if (bus1.owner !== 2'b00 || bus0.owner !== 2'b00) begin
      errors++;
      $display("FAIL t3_before_latency: owners %b %b expected 00 00", bus1.owner, bus0.owner);
    end
    tick(1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t3_remote_prio: scoreboard empty, got %b", obs1);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs1 !== exp_v) begin
        errors++;
        $display("FAIL t3_remote_prio: got %b expected %b", obs1, exp_v);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL t3_local_prio: scoreboard empty, got %b", obs0);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs0 !== exp_v) begin
        errors++;
        $display("FAIL t3_local_prio: got %b expected %b", obs0, exp_v);
      end
    end
    tick(1);
    checks++;
    if (bus1.talker_change !== 1'b0 || bus1.collision !== 1'b0 || bus0.collision !== 1'b0) begin
      errors++;
      $display("FAIL t3_after: tc %b col %b col0 %b expected 0 0 0", bus1.talker_change, bus1.collision, bus0.collision);
    end
    local_key = 1'b0;
    remote_key = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    local_key = 1'b0;
    remote_key = 1'b0;
    test_reset();
    test_glitch();
    test_local_grant();
    test_collision();
    test_timeout_holdoff();
    test_reset_mid_owner();
    test_simultaneous();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
